// File: rtl/dac_writer_pkg.sv
// rtl/dac_writer_pkg.sv - shared constants, state encoding and helpers for the DAC sample writer
//
// Purpose: one place for the frame layout (command nibble + sample), the default
// DAC command and the transmitter state encoding.
// Ports: none (package).

package dac_writer_pkg;

  localparam int CMD_W      = 4;
  localparam int DEF_DATA_W = 12;
  localparam int FRAME_W    = CMD_W + DEF_DATA_W;

  // Write-and-update command, sent ahead of the sample bits.
  localparam logic [CMD_W-1:0] DEF_DAC_CMD = 4'b0011;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SETUP = 3'd2,
    HI    = 3'd3,
    LO    = 3'd4,
    GAP   = 3'd5
  } state_e;

  // Terminal value for an up-counter that must run for n cycles.
  function automatic logic [7:0] lastCount(input int n);
    return 8'(n - 1);
  endfunction

endpackage

// File: rtl/dac_sample_writer_if.sv
// rtl/dac_sample_writer_if.sv - sample-in / SPI-out bundle for the DAC sample writer
//
// Purpose: groups the filter-side sample handshake and the DAC-side SPI pins.
// Signals:
//   iDataIn       sample word, valid on the iSampleReady rising edge
//   iSampleReady  level flag, each 0->1 transition is one new sample
//   oSclk/oMosi/oCsN  SPI mode 0 pins towards the DAC
//   oBusy, oFrameDone, oOverrun  status back towards the system
// Modports: master = sample producer / pin observer, slave = the writer itself.

interface dac_sample_writer_if
  import dac_writer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic [DATA_W-1:0] iDataIn;
  logic              iSampleReady;
  logic              oSclk;
  logic              oMosi;
  logic              oCsN;
  logic              oBusy;
  logic              oFrameDone;
  logic              oOverrun;

  modport master (
    output iDataIn, iSampleReady,
    input  oSclk, oMosi, oCsN, oBusy, oFrameDone, oOverrun
  );

  modport slave (
    input  iDataIn, iSampleReady,
    output oSclk, oMosi, oCsN, oBusy, oFrameDone, oOverrun
  );

endinterface

// File: rtl/dac_sample_writer_spi_frame_tx.sv
// rtl/dac_sample_writer_spi_frame_tx.sv - SPI mode 0 frame transmitter with CS gap
//
// Purpose: shifts one FRAME_BITS word out MSB first, CLK_DIV clk cycles per SCLK
// half period, then holds CS high for CS_GAP cycles before accepting the next word.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   iStart        request to send iData; accepted only while oReady=1
//   oReady        high in IDLE and on the last GAP cycle
//   oLoad         high during the LOAD cycle, when iData is captured
//   iData         frame word (command + sample)
//   oSclk, oMosi, oCsN  SPI pins
//   oBusy         high from LOAD to the end of GAP
//   oFrameDone    one-cycle pulse in the first cycle CS is high again

module spi_frame_tx
  import dac_writer_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_W,
  parameter int CLK_DIV    = 4,
  parameter int CS_GAP     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iStart,
  output logic                  oReady,
  output logic                  oLoad,
  input  logic [FRAME_BITS-1:0] iData,
  output logic                  oSclk,
  output logic                  oMosi,
  output logic                  oCsN,
  output logic                  oBusy,
  output logic                  oFrameDone
);

  localparam logic [2:0] ST_IDLE  = IDLE;
  localparam logic [2:0] ST_LOAD  = LOAD;
  localparam logic [2:0] ST_SETUP = SETUP;
  localparam logic [2:0] ST_HI    = HI;
  localparam logic [2:0] ST_LO    = LO;
  localparam logic [2:0] ST_GAP   = GAP;

  localparam logic [7:0] DIV_LAST  = lastCount(CLK_DIV);
  localparam logic [7:0] GAP_LAST  = lastCount(CS_GAP);
  localparam logic [4:0] BITS_LAST = 5'(FRAME_BITS);

  logic [2:0]            state;
  logic [7:0]            divCnt;
  logic [4:0]            bitCnt;
  logic [FRAME_BITS-1:0] shreg;
  logic                  phaseEnd;
  logic                  gapEnd;
  logic                  csActive;

  assign phaseEnd = (divCnt == DIV_LAST);
  assign gapEnd   = (divCnt == GAP_LAST);
  assign csActive = (state == ST_SETUP) || (state == ST_HI) || (state == ST_LO);

  assign oReady     = (state == ST_IDLE) || ((state == ST_GAP) && gapEnd);
  assign oLoad      = (state == ST_LOAD);
  assign oCsN       = ~csActive;
  assign oSclk      = (state == ST_HI);
  assign oMosi      = csActive & shreg[FRAME_BITS-1];
  assign oBusy      = (state != ST_IDLE);
  assign oFrameDone = (state == ST_GAP) && (divCnt == 8'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      divCnt <= 8'd0;
      bitCnt <= 5'd0;
      shreg  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          divCnt <= 8'd0;
          if (iStart) state <= ST_LOAD;
        end
        ST_LOAD: begin
          shreg  <= iData;
          divCnt <= 8'd0;
          bitCnt <= 5'd0;
          state  <= ST_SETUP;
        end
        ST_SETUP: begin
          if (phaseEnd) begin
            divCnt <= 8'd0;
            state  <= ST_HI;
          end else begin
            divCnt <= divCnt + 8'd1;
          end
        end
        ST_HI: begin
          if (phaseEnd) begin
            divCnt <= 8'd0;
            bitCnt <= bitCnt + 5'd1;
            // No shift after the last bit: the final LO phase is CS hold time
            // and MOSI must stay on the last data bit.
            if (bitCnt != BITS_LAST - 5'd1)
              shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
            state <= ST_LO;
          end else begin
            divCnt <= divCnt + 8'd1;
          end
        end
        ST_LO: begin
          if (phaseEnd) begin
            divCnt <= 8'd0;
            state  <= (bitCnt == BITS_LAST) ? ST_GAP : ST_HI;
          end else begin
            divCnt <= divCnt + 8'd1;
          end
        end
        ST_GAP: begin
          if (gapEnd) begin
            divCnt <= 8'd0;
            state  <= iStart ? ST_LOAD : ST_IDLE;
          end else begin
            divCnt <= divCnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/dac_sample_writer.sv
// rtl/dac_sample_writer.sv - sample edge detect, one-entry buffer and SPI DAC frame launch
//
// Purpose: turns each rising edge of the level-style sample-ready flag into one
// SPI DAC write frame of {DAC_CMD, sample}. One sample may wait while a frame is
// in flight; a newer one overwrites it and flags oOverrun.
// Ports:
//   clk   system clock
//   rst   asynchronous active-low reset (aborts any frame, CS high at once)
//   bus   dac_sample_writer_if.slave: iDataIn/iSampleReady in, SPI pins and
//         oBusy/oFrameDone/oOverrun out

module dac_sample_writer
  import dac_writer_pkg::*;
#(
  parameter int               DATA_W  = DEF_DATA_W,
  parameter logic [CMD_W-1:0] DAC_CMD = DEF_DAC_CMD,
  parameter int               CLK_DIV = 4,
  parameter int               CS_GAP  = 2
) (
  input logic                clk,
  input logic                rst,
  dac_sample_writer_if.slave bus
);

  logic              rdyQ;
  logic              sampleEdge;
  logic              holdValid;
  logic [DATA_W-1:0] holdData;
  logic              overrunQ;
  logic              txReady;
  logic              txLoad;
  logic              txStart;

  // rdyQ resets to 0 so a flag already high at reset release is one edge.
  assign sampleEdge = bus.iSampleReady & ~rdyQ;
  assign txStart    = holdValid & txReady;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdyQ      <= 1'b0;
      holdValid <= 1'b0;
      holdData  <= '0;
      overrunQ  <= 1'b0;
    end else begin
      rdyQ <= bus.iSampleReady;
      // The transmitter captures holdData in LOAD with the old value, so an
      // edge in that same cycle simply refills the buffer: no overrun.
      overrunQ <= sampleEdge & holdValid & ~txLoad;
      if (sampleEdge) begin
        holdData  <= bus.iDataIn;
        holdValid <= 1'b1;
      end else if (txLoad) begin
        holdValid <= 1'b0;
      end
    end
  end

  assign bus.oOverrun = overrunQ;

  spi_frame_tx #(
    .FRAME_BITS(CMD_W + DATA_W),
    .CLK_DIV   (CLK_DIV),
    .CS_GAP    (CS_GAP)
  ) uTx (
    .clk       (clk),
    .rst       (rst),
    .iStart    (txStart),
    .oReady    (txReady),
    .oLoad     (txLoad),
    .iData     ({DAC_CMD, holdData}),
    .oSclk     (bus.oSclk),
    .oMosi     (bus.oMosi),
    .oCsN      (bus.oCsN),
    .oBusy     (bus.oBusy),
    .oFrameDone(bus.oFrameDone)
  );

endmodule
